// File: rtl/run_seg_n.sv
// run_seg_n: running-digit engine for the seven-segment display path.
// A NUM_DIG-nibble word is shown static, rotated left or right, or
// blinked. Each display update comes from a millisecond prescaler and a
// step counter whose terminal value is selected at runtime by speed_sel.
// This is a single register stage, so all state carries the _p0 suffix.
module run_seg_n #(
  parameter int NUM_DIG  = 8,
  parameter int CLK_FREQ = 50_000_000,
  parameter int STEP_MS  = 512
) (
  input  logic                   CLOCK_50,
  input  logic                   rst,
  input  logic [4*NUM_DIG-1:0]   indata,
  input  logic                   load,
  input  logic [1:0]             mode,
  input  logic [1:0]             speed_sel,
  input  logic                   pause,
  output logic [4*NUM_DIG-1:0]   outdata,
  output logic [NUM_DIG-1:0]     blank,
  output logic                   step
);

  localparam int DATA_W = 4 * NUM_DIG;
  localparam int PRESC  = CLK_FREQ / 1000;
  localparam int PW     = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int MS_W   = $clog2(STEP_MS);

  localparam logic [PW-1:0] PRESC_TOP = PW'(PRESC - 1);

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_LEFT   = 2'b01;
  localparam logic [1:0] MODE_RIGHT  = 2'b10;
  localparam logic [1:0] MODE_BLINK  = 2'b11;

  logic [PW-1:0]     presc_p0;
  logic [MS_W-1:0]   ms_cnt_p0;
  logic [DATA_W-1:0] shadow_p0;
  logic [1:0]        mode_q_p0;

  logic              tick;
  logic [MS_W-1:0]   ms_term;
  logic              step_evt;

  // The most significant digit wraps around into digit 0.
  function automatic logic [DATA_W-1:0] rot_left(input logic [DATA_W-1:0] d);
    return {d[DATA_W-5:0], d[DATA_W-1:DATA_W-4]};
  endfunction

  // Digit 0 wraps around into the most significant digit.
  function automatic logic [DATA_W-1:0] rot_right(input logic [DATA_W-1:0] d);
    return {d[3:0], d[DATA_W-1:4]};
  endfunction

  // Terminal count of the ms counter tracks speed_sel combinationally, so a
  // speed change takes effect at once. A counter already beyond the new
  // terminal simply runs on and wraps at MS_W bits.
  assign ms_term  = MS_W'((STEP_MS >> speed_sel) - 1);
  assign tick     = (presc_p0 == PRESC_TOP);
  assign step_evt = tick && (ms_cnt_p0 == ms_term);

  // Restart (load or mode change), pause hold, and step-driven display update.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      presc_p0  <= '0;
      ms_cnt_p0 <= '0;
      shadow_p0 <= '0;
      mode_q_p0 <= MODE_STATIC;
      outdata   <= '0;
      blank     <= '0;
      step      <= 1'b0;
    end else if (load) begin
      // A load also absorbs a coincident mode change: one restart only.
      shadow_p0 <= indata;
      outdata   <= indata;
      blank     <= '0;
      presc_p0  <= '0;
      ms_cnt_p0 <= '0;
      mode_q_p0 <= mode;
      step      <= 1'b0;
    end else if (mode != mode_q_p0) begin
      outdata   <= shadow_p0;
      blank     <= '0;
      presc_p0  <= '0;
      ms_cnt_p0 <= '0;
      mode_q_p0 <= mode;
      step      <= 1'b0;
    end else if (pause) begin
      step <= 1'b0;
    end else begin
      presc_p0 <= tick ? '0 : presc_p0 + 1'b1;
      step     <= step_evt;
      if (tick) begin
        ms_cnt_p0 <= step_evt ? '0 : ms_cnt_p0 + 1'b1;
      end
      if (step_evt) begin
        case (mode_q_p0)
          MODE_LEFT:  outdata <= rot_left(outdata);
          MODE_RIGHT: outdata <= rot_right(outdata);
          MODE_BLINK: begin
            blank   <= ~blank;
            outdata <= shadow_p0;
          end
          default:    outdata <= outdata;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_run_seg_n.sv
// tb_run_seg_n: directed scenarios plus a randomized run, every cycle
// compared against a cycle-counting reference model of the display engine.
module tb_run_seg_n;

  localparam int N       = 8;
  localparam int CLK_F   = 4000;
  localparam int STEP_MS = 8;
  localparam int CPM     = CLK_F / 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   indata;
  logic          load;
  logic [1:0]    mode;
  logic [1:0]    speed_sel;
  logic          pause;
  logic [31:0]   outdata;
  logic [N-1:0]  blank;
  logic          step;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0]  m_out;
  logic [31:0]  m_shadow;
  logic [N-1:0] m_blank;
  logic         m_step;
  logic [1:0]   m_mode_q;
  int           m_cnt;

  run_seg_n #(.NUM_DIG(N), .CLK_FREQ(CLK_F), .STEP_MS(STEP_MS)) dut (
    .CLOCK_50 (clk),
    .rst      (rst),
    .indata   (indata),
    .load     (load),
    .mode     (mode),
    .speed_sel(speed_sel),
    .pause    (pause),
    .outdata  (outdata),
    .blank    (blank),
    .step     (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Rotate by digit index: dir=1 moves every digit one place to the left.
  function automatic logic [31:0] rot(input logic [31:0] d, input bit dir);
    logic [31:0] r;
    int src;
    r = '0;
    for (int k = 0; k < N; k++) begin
      src = dir ? (k + N - 1) % N : (k + 1) % N;
      r[4*k +: 4] = d[4*src +: 4];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_out = '0; m_shadow = '0; m_blank = '0; m_step = 1'b0;
    m_mode_q = 2'b00; m_cnt = 0;
  endtask

  // One clock of the model: a step occurs every STEP_CYC active cycles.
  task automatic model_clock();
    int step_cyc;
    step_cyc = CPM * (STEP_MS >> speed_sel);
    if (rst) model_reset();
    else if (load) begin
      m_shadow = indata; m_out = indata; m_blank = '0;
      m_cnt = 0; m_step = 1'b0; m_mode_q = mode;
    end else if (mode != m_mode_q) begin
      m_out = m_shadow; m_blank = '0; m_cnt = 0; m_step = 1'b0; m_mode_q = mode;
    end else if (pause) begin
      m_step = 1'b0;
    end else begin
      m_cnt++;
      m_step = 1'b0;
      if (m_cnt == step_cyc) begin
        m_cnt = 0;
        m_step = 1'b1;
        case (m_mode_q)
          2'b01: m_out = rot(m_out, 1'b1);
          2'b10: m_out = rot(m_out, 1'b0);
          2'b11: begin m_blank = ~m_blank; m_out = m_shadow; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_clock();
    #1;
    chk("out",   outdata, m_out);
    chk("blank", {24'h0, blank}, {24'h0, m_blank});
    chk("step",  {31'h0, step}, {31'h0, m_step});
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic do_load(input logic [31:0] d, input logic [1:0] md, input logic [1:0] sp);
    indata = d; mode = md; speed_sel = sp; load = 1'b1;
    run_cycle();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; indata = '0; load = 1'b0; mode = 2'b00; speed_sel = 2'b00; pause = 1'b0;
    model_reset();
    #1;
    chk("rst_out",   outdata, 32'h0);
    chk("rst_blank", {24'h0, blank}, 32'h0);
    chk("rst_step",  {31'h0, step}, 32'h0);
    run_n(3);
    rst = 1'b0;

    // Scroll left: visible next cycle, first step at +32, wraps after 8 steps
    do_load(32'h87654321, 2'b01, 2'b00);
    chk("load_vis", outdata, 32'h87654321);
    run_n(31);
    chk("l_quiet", {31'h0, step}, 32'h0);
    run_cycle();
    chk("l_step", {31'h0, step}, 32'h1);
    chk("l_out1", outdata, 32'h76543218);
    run_n(7 * 32);
    chk("l_wrap", outdata, 32'h87654321);
    chk("l_wrap_step", {31'h0, step}, 32'h1);

    // Scroll right with a one-cycle step pulse
    do_load(32'h87654321, 2'b10, 2'b00);
    run_n(32);
    chk("r_out1", outdata, 32'h18765432);
    chk("r_step", {31'h0, step}, 32'h1);
    run_cycle();
    chk("r_step_w", {31'h0, step}, 32'h0);

    // Blink at speed 2: step every 8 cycles
    do_load(32'h87654321, 2'b11, 2'b10);
    run_n(8);
    chk("b_ff1", {24'h0, blank}, 32'hff);
    run_n(8);
    chk("b_00", {24'h0, blank}, 32'h00);
    run_n(8);
    chk("b_ff2", {24'h0, blank}, 32'hff);
    chk("b_out", outdata, 32'h87654321);
    mode = 2'b00;
    run_cycle();
    chk("b_static", {24'h0, blank}, 32'h00);

    // Pause for 50 cycles starting at cycle 20: first step lands at 82
    do_load(32'h87654321, 2'b01, 2'b00);
    run_n(20);
    pause = 1'b1;
    run_n(50);
    pause = 1'b0;
    run_n(11);
    chk("p_quiet", {31'h0, step}, 32'h0);
    run_cycle();
    chk("p_step", {31'h0, step}, 32'h1);
    chk("p_out", outdata, 32'h76543218);

    // Load on the exact step cycle: load wins, next step 32 later
    do_load(32'h87654321, 2'b01, 2'b00);
    run_n(31);
    do_load(32'h0badcafe, 2'b01, 2'b00);
    chk("ls_out", outdata, 32'h0badcafe);
    chk("ls_step", {31'h0, step}, 32'h0);
    run_n(31);
    chk("ls_quiet", {31'h0, step}, 32'h0);
    run_cycle();
    chk("ls_step2", {31'h0, step}, 32'h1);
    chk("ls_out2", outdata, 32'hbadcafe0);

    // Asynchronous reset mid-scroll, between clock edges
    run_n(10);
    rst = 1'b1;
    #1;
    chk("ar_out",   outdata, 32'h0);
    chk("ar_blank", {24'h0, blank}, 32'h0);
    chk("ar_step",  {31'h0, step}, 32'h0);
    model_reset();
    run_n(2);
    rst = 1'b0;
    run_n(40);

    // Randomized run; speed only changes together with a load
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        indata = $urandom; speed_sel = 2'($urandom_range(0, 3)); load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 299) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) pause = ~pause;
      run_cycle();
    end
    load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
